// File: rtl/imem_fetch_loader.sv
// imem_fetch_loader: instruction memory for the single-cycle core.
// A program is streamed into word memory over the load port. The core is
// then released with `run` and served one registered instruction per
// cycle until the halt opcode or a misaligned PC stops it.
//
// Load handshake: a word transfers on a rising edge where load_valid and
// load_ready are both high. The producer keeps load_data/load_last stable
// while load_valid is high and load_ready is low. load_ready never depends
// combinationally on load_valid.
`timescale 1ns/1ps
module imem_fetch_loader #(
    parameter int          DEPTH   = 256,
    parameter logic [31:0] HALT_OP = 32'h0000007f,
    parameter logic [31:0] NOP_OP  = 32'h00000013
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    input  logic [10:0] PC,
    output logic [31:0] instr,
    output logic        run,
    output logic        halted,
    output logic        fault,
    output logic [9:0]  word_count,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [9:0] DEPTH_W = 10'(DEPTH);
    localparam logic [9:0] LAST_W  = 10'(DEPTH - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] mem [DEPTH];

    logic [8:0]  pc_word;
    logic        pc_misaligned;
    logic        pc_in_range;
    logic [31:0] fetch_word;
    logic        accept;
    logic        load_done;
    logic        fetch_stop;
    logic        restart;

    assign pc_word       = PC[10:2];
    assign pc_misaligned = (PC[1:0] != 2'b00);
    // Only words written by the current load are valid; the rest read as NOP.
    assign pc_in_range   = ({1'b0, pc_word} < word_count);
    assign accept        = (state == S_LOAD) && load_valid && load_ready;
    // Filling the last slot is treated as an implicit load_last.
    assign load_done     = accept && (load_last || (word_count == LAST_W));
    assign fetch_stop    = pc_misaligned || (fetch_word == HALT_OP);
    // load_start re-enters LOAD from every state except LOAD itself.
    assign restart       = load_start && (state != S_LOAD);

    // Word selected for the next instr register value.
    always_comb begin
        fetch_word = NOP_OP;
        if (!pc_misaligned && pc_in_range) begin
            fetch_word = mem[pc_word[AW-1:0]];
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; load_start outranks a halt or fault in RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (load_start) state_nxt = S_LOAD;
            S_LOAD: if (load_done)  state_nxt = S_RUN;
            S_RUN: begin
                if (load_start) begin
                    state_nxt = S_LOAD;
                end else if (fetch_stop) begin
                    state_nxt = S_HALT;
                end
            end
            S_HALT: if (load_start) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        load_ready = (state == S_LOAD) && (word_count != DEPTH_W);
        run        = (state == S_RUN);
        halted     = (state == S_HALT);
        fsm_state  = state;
    end

    // Program memory: written only while loading, so reads never collide.
    always_ff @(posedge CLOCK_50) begin
        if (accept) begin
            mem[word_count[AW-1:0]] <= load_data;
        end
    end

    // Count of words accepted since the last load_start.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            word_count <= 10'd0;
        end else if (restart) begin
            word_count <= 10'd0;
        end else if (accept) begin
            word_count <= word_count + 10'd1;
        end
    end

    // Sticky misaligned-fetch flag, cleared only by a new load.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            fault <= 1'b0;
        end else if (restart) begin
            fault <= 1'b0;
        end else if ((state == S_RUN) && pc_misaligned) begin
            fault <= 1'b1;
        end
    end

    // Fetch register: one instruction per edge in RUN, held otherwise.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            instr <= NOP_OP;
        end else if (state == S_RUN) begin
            instr <= fetch_word;
        end
    end

endmodule

// File: tb/tb_imem_fetch_loader.sv
// Testbench for imem_fetch_loader: directed test-plan steps followed by
// randomized programs and fetches, checked against a transaction-level
// model of the loader and fetch rules.
`timescale 1ns/1ps
module tb_imem_fetch_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] HALT  = 32'h0000007f;
    localparam logic [31:0] NOP   = 32'h00000013;

    // ---------------- clock / reset / DUT ----------------
    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic [10:0] PC;
    logic [31:0] instr;
    logic        run;
    logic        halted;
    logic        fault;
    logic [9:0]  word_count;
    logic [1:0]  fsm_state;

    always #10 CLOCK_50 = ~CLOCK_50;

    imem_fetch_loader #(.DEPTH(DEPTH), .HALT_OP(HALT), .NOP_OP(NOP)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .PC         (PC),
        .instr      (instr),
        .run        (run),
        .halted     (halted),
        .fault      (fault),
        .word_count (word_count),
        .fsm_state  (fsm_state)
    );

    // ---------------- reference model ----------------
    int          errors = 0;
    int          checks = 0;
    bit          m_loading;
    bit          m_running;
    bit          m_halted;
    bit          m_fault;
    int          m_count;
    logic [31:0] m_instr;
    logic [31:0] mem_model [DEPTH];

    task automatic model_reset();
        m_loading = 0;
        m_running = 0;
        m_halted  = 0;
        m_fault   = 0;
        m_count   = 0;
        m_instr   = NOP;
    endtask

    // Apply the block's rules for one rising edge using the current inputs.
    task automatic model_edge();
        logic [31:0] w;
        bit          stop;
        bit          mis;
        bit          ready;
        int          idx;
        stop  = 0;
        mis   = 0;
        ready = m_loading && (m_count < DEPTH);
        if (m_running) begin
            idx = int'(PC[10:2]);
            mis = (PC[1:0] != 2'b00);
            if (mis)                w = NOP;
            else if (idx < m_count) w = mem_model[idx];
            else                    w = NOP;
            m_instr = w;
            stop    = mis || (w == HALT);
        end
        if (load_start && !m_loading) begin
            m_loading = 1;
            m_running = 0;
            m_halted  = 0;
            m_fault   = 0;
            m_count   = 0;
        end else if (m_loading) begin
            if (load_valid && ready) begin
                mem_model[m_count] = load_data;
                m_count++;
                if (load_last || m_count == DEPTH) begin
                    m_loading = 0;
                    m_running = 1;
                end
            end
        end else if (m_running && stop) begin
            m_running = 0;
            m_halted  = 1;
            if (mis) m_fault = 1;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        int exp_state;
        exp_state = m_loading ? 1 : (m_running ? 2 : (m_halted ? 3 : 0));
        check({ctx, ".instr"},      instr,                     m_instr);
        check({ctx, ".run"},        32'(run),                  32'(m_running));
        check({ctx, ".halted"},     32'(halted),               32'(m_halted));
        check({ctx, ".fault"},      32'(fault),                32'(m_fault));
        check({ctx, ".load_ready"}, 32'(load_ready),           32'(m_loading && (m_count < DEPTH)));
        check({ctx, ".word_count"}, 32'(word_count),           32'(m_count));
        check({ctx, ".state"},      32'(fsm_state),            32'(exp_state));
    endtask

    // ---------------- drivers ----------------
    task automatic tick(input string ctx);
        model_edge();
        @(posedge CLOCK_50);
        #1;
        check_all(ctx);
    endtask

    task automatic start_load();
        PC         = 11'd0;
        load_start = 1'b1;
        tick("start");
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last, input string ctx);
        load_valid = 1'b1;
        load_data  = w;
        load_last  = last;
        tick(ctx);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [10:0] pc, input string ctx);
        PC = pc;
        tick(ctx);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] prog [4];
        int          n;

        reset_n    = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 32'd0;
        load_last  = 1'b0;
        PC         = 11'd0;
        model_reset();
        #35;
        check_all("reset");
        check("reset.instr_nop", instr, NOP);
        reset_n = 1'b1;
        tick("idle");

        // Basic load and fetch
        start_load();
        check("start.ready_up", 32'(load_ready), 32'd1);
        prog[0] = 32'h00500293;
        prog[1] = 32'h00c000ef;
        prog[2] = 32'h00102623;
        prog[3] = HALT;
        for (int i = 0; i < 4; i++) send_word(prog[i], (i == 3), "basic_load");
        check("basic.word_count", 32'(word_count), 32'd4);
        check("basic.run", 32'(run), 32'd1);
        fetch(11'h000, "basic_pc0");
        check("basic.instr0", instr, 32'h00500293);
        fetch(11'h004, "basic_pc4");
        check("basic.instr4", instr, 32'h00c000ef);
        fetch(11'h008, "basic_pc8");
        check("basic.instr8", instr, 32'h00102623);

        // Halt on the halt opcode
        fetch(11'h00c, "halt_pc");
        check("halt.instr", instr, HALT);
        check("halt.run", 32'(run), 32'd0);
        check("halt.halted", 32'(halted), 32'd1);
        fetch(11'h000, "halt_hold1");
        fetch(11'h004, "halt_hold2");
        check("halt.hold", instr, HALT);

        // Out-of-range and misaligned PC
        start_load();
        send_word(32'h11111111, 1'b0, "oor_load");
        send_word(32'h22222222, 1'b1, "oor_load");
        fetch(11'h010, "oor_pc");
        check("oor.instr", instr, NOP);
        check("oor.run", 32'(run), 32'd1);
        fetch(11'h002, "mis_pc");
        check("mis.fault", 32'(fault), 32'd1);
        check("mis.halted", 32'(halted), 32'd1);
        check("mis.instr", instr, NOP);

        // Reload from HALT
        start_load();
        check("reload.fault", 32'(fault), 32'd0);
        check("reload.word_count", 32'(word_count), 32'd0);
        send_word(32'h00900113, 1'b0, "reload_load");
        send_word(HALT, 1'b1, "reload_load");
        fetch(11'h000, "reload_pc0");
        check("reload.instr0", instr, 32'h00900113);
        fetch(11'h004, "reload_pc4");

        // Back-pressure and full memory: five words, no load_last
        start_load();
        for (int i = 0; i < 5; i++) begin
            send_word(32'hA0000000 | 32'(i), 1'b0, "full_load");
            if (i == 3) begin
                check("full.run", 32'(run), 32'd1);
                check("full.ready_low", 32'(load_ready), 32'd0);
            end
        end
        check("full.word_count", 32'(word_count), 32'd4);
        for (int i = 0; i < 5; i++) fetch(11'(i * 4), "full_fetch");
        check("full.oor_instr", instr, NOP);

        // Randomized programs and fetches
        for (int it = 0; it < 30; it++) begin
            start_load();
            n = $urandom_range(1, DEPTH + 1);
            for (int i = 0; i < n; i++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) tick("rnd_gap");
                send_word(($urandom_range(0, 9) == 0) ? HALT : $urandom,
                          (i == n - 1), "rnd_load");
            end
            for (int f = 0; f < 10; f++) begin
                if ($urandom_range(0, 9) == 0) fetch(11'($urandom_range(0, 63)), "rnd_fetch");
                else                           fetch(11'($urandom_range(0, 7) * 4), "rnd_fetch");
            end
        end

        // Asynchronous reset in the middle of a load
        start_load();
        send_word(32'h0badf00d, 1'b0, "arst_load");
        send_word(32'h12345678, 1'b0, "arst_load");
        check("arst.pre_count", 32'(word_count), 32'd2);
        #5;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        check("arst.instr", instr, NOP);
        check("arst.word_count", 32'(word_count), 32'd0);
        #4;
        reset_n = 1'b1;
        tick("arst_idle");
        start_load();
        send_word(32'h00100093, 1'b1, "arst_reload");
        fetch(11'h000, "arst_fetch");
        check("arst.recover", instr, 32'h00100093);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
